countdown_sequencer: RTL and testbench
======================================

// Module: countdown_sequencer
//
// PURPOSE
//   Loadable down-counting step sequencer: the consuming end of the step-count path.
//   On start it takes a count N and issues exactly N step strobes, one per
//   non-held cycle. It then raises done until acknowledged.
//   It paces multi-cycle ALU operations such as shift-add multiply and restoring divide.
//   The decrement is built from adder_rca (remaining + all-ones, carry_in 0), and the
//   state and count registers use dff cells.
//
// PARAMETERS
//   WIDTH  3  width of load_value/remaining; max step count 2^WIDTH-1
//
// PORTS
//   clk         in   1      rising-edge clock, single clock domain
//   reset       in   1      asynchronous, active-low reset (0 = reset)
//   start       in   1      request; samples load_value when in IDLE
//   load_value  in   WIDTH  number of steps N to issue
//   hold        in   1      freeze RUN this cycle (no step, no decrement)
//   abort       in   1      cancel RUN, return to IDLE without done
//   done_ack    in   1      consumer acknowledges done
//   step        out  1      one strobe per executed step (combinational)
//   busy        out  1      state == RUN
//   done        out  1      state == DONE
//   remaining   out  WIDTH  steps still to issue (registered)
//
// BEHAVIOUR
//   Reset (reset==0, no clock required): state=IDLE, remaining=0.
//     This forces step=0, busy=0 and done=0 immediately, including mid-run.
//   FSM states are IDLE, RUN and DONE, with 2-bit encoding 00/01/10.
//     Encoding 11 is illegal and goes to IDLE on the next edge.
//   IDLE: when start=1, remaining<=load_value.
//     If load_value!=0, next state is RUN; if load_value==0, next state is DONE.
//   RUN: step = ~hold & ~abort. Priority is abort > hold > decrement.
//     abort=1: next state IDLE, remaining<=0, no step that cycle.
//     hold=1 (no abort): state and remaining unchanged.
//     Otherwise: remaining<=remaining-1. When remaining==1 the next state is DONE.
//   DONE: done=1 and remaining=0 are held until done_ack=1, then next state is IDLE.
//     start in the same cycle as done_ack is ignored. A new start is needed in IDLE.
//   start is ignored in RUN and DONE. done_ack and hold are ignored outside their states.
//   Latency: take start sampled at edge E0 with load N>0 and no hold.
//     step is high in the N cycles after E0, and done rises after edge EN.
//     Each held cycle adds 1 to this latency.
//   Width rule: remaining never decrements below 0, so no wrap-around occurs.
//     The adder carry_out is unused.
//   Total step pulses always equal N unless abort is asserted.
//
// TESTING
//   1. reset; start with load_value=5 -> step high 5 consecutive cycles.
//      remaining reads 5,4,3,2,1,0; done rises after 5th edge; done stays high until done_ack.
//   2. start with load_value=0 -> DONE after one edge.
//      Zero step pulses and busy never high.
//   3. load 4; hold=1 for 2 cycles after 2nd step -> remaining frozen at 2 during hold.
//      4 steps total; done 6 edges after start.
//   4. load 6; abort when remaining=3 -> IDLE next edge.
//      remaining=0, done never asserts, exactly 3 steps issued.
//   5. load 7 at WIDTH=3; assert reset=0 between edges at remaining=4.
//      All outputs go to 0 with no clock edge; after release the block idles until start.
//   6. load 7 at WIDTH=3 -> 7 steps, no wrap.
//      start during RUN is ignored; start with done_ack in DONE -> IDLE, no restart.

Source files
------------

// File: rtl/countdown_sequencer.sv
// -----------------------------------------------------------------------------
// countdown_sequencer
//   Loadable down-counting step sequencer. A start in IDLE loads N steps; the
//   block then issues one step strobe per non-held RUN cycle until the count
//   is exhausted, and holds done until the consumer acknowledges it.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       load request, honoured only in IDLE
//   load_value  step count N to issue
//   hold        freeze RUN for this cycle
//   abort       cancel RUN, back to IDLE without done
//   done_ack    acknowledge of done
//   step        step strobe (combinational from state and hold/abort)
//   busy        state is RUN
//   done        state is DONE
//   remaining   steps still to issue (registered)
// -----------------------------------------------------------------------------
module countdown_sequencer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    input  logic             hold,
    input  logic             abort,
    input  logic             done_ack,
    output logic             step,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE = 2'b00;
    localparam logic [STATE_W-1:0] S_RUN  = 2'b01;
    localparam logic [STATE_W-1:0] S_DONE = 2'b10;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [WIDTH-1:0]   remaining_q;
    logic [WIDTH-1:0]   remaining_d;
    logic [WIDTH-1:0]   dec_sum;

    // Ripple-carry decrement: remaining + all-ones with carry-in 0.
    // Carry-out is discarded; RUN never decrements from zero.
    always_comb begin
        logic carry;
        carry   = 1'b0;
        dec_sum = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            dec_sum[i] = remaining_q[i] ^ 1'b1 ^ carry;
            carry      = remaining_q[i] | carry;
        end
    end

    // State and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Next-state and next-count logic.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = load_value;
                    state_d     = (load_value != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end else if (!hold) begin
                    remaining_d = dec_sum;
                    if (remaining_q == WIDTH'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (done_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                // Illegal encoding recovers to IDLE with a cleared count.
                state_d     = S_IDLE;
                remaining_d = '0;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        step = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        if (state_q == S_RUN) begin
            busy = 1'b1;
            step = ~hold & ~abort;
        end
        if (state_q == S_DONE) begin
            done = 1'b1;
        end
    end

    assign remaining = remaining_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// -----------------------------------------------------------------------------
// tb_countdown_sequencer
//   Directed scenarios followed by random stimulus, each cycle compared with a
//   count-based reference model of the sequencer.
// -----------------------------------------------------------------------------
module tb_countdown_sequencer;

    localparam int unsigned WIDTH = 3;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] load_value;
    logic             hold;
    logic             abort;
    logic             done_ack;
    logic             step;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] remaining;

    int total;
    int bad;

    // Reference model: outstanding count plus "running" / "finished" flags.
    int m_rem;
    bit m_run;
    bit m_fin;
    int m_steps;
    int dut_steps;
    int base;

    countdown_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_value (load_value),
        .hold       (hold),
        .abort      (abort),
        .done_ack   (done_ack),
        .step       (step),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic do_cycle(input bit s, input int lv, input bit h, input bit a, input bit ack);
        bit exp_step;
        start      = s;
        load_value = WIDTH'(lv);
        hold       = h;
        abort      = a;
        done_ack   = ack;
        @(negedge clk);
        exp_step = m_run && !h && !a;
        check("step", 32'(step), 32'(exp_step));
        check("busy", 32'(busy), 32'(m_run));
        check("done", 32'(done), 32'(m_fin));
        check("remaining", 32'(remaining), 32'(m_rem));
        if (step === 1'b1) dut_steps++;
        if (exp_step) m_steps++;
        @(posedge clk);
        if (m_run) begin
            if (a) begin
                m_run = 1'b0;
                m_rem = 0;
            end else if (!h) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_run = 1'b0;
                    m_fin = 1'b1;
                end
            end
        end else if (m_fin) begin
            if (ack) m_fin = 1'b0;
        end else if (s) begin
            m_rem = lv;
            if (lv > 0) m_run = 1'b1;
            else        m_fin = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        m_rem = 0;
        m_run = 1'b0;
        m_fin = 1'b0;
        m_steps = 0;
        dut_steps = 0;
        reset = 1'b0;
        start = 1'b0;
        load_value = '0;
        hold = 1'b0;
        abort = 1'b0;
        done_ack = 1'b0;

        // Reset state
        #2;
        check("rst_step", 32'(step), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);

        // 1: load 5, five consecutive steps, done held until ack
        base = dut_steps;
        do_cycle(1'b1, 5, 1'b0, 1'b0, 1'b0);
        idle(5);
        check("t1_steps", 32'(dut_steps - base), 32'd5);
        idle(3);
        check("t1_done_held", 32'(done), 32'd1);
        do_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // 2: load 0 goes straight to DONE, no steps
        base = dut_steps;
        do_cycle(1'b1, 0, 1'b0, 1'b0, 1'b0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        do_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("t2_steps", 32'(dut_steps - base), 32'd0);

        // 3: load 4, two held cycles after the second step
        base = dut_steps;
        do_cycle(1'b1, 4, 1'b0, 1'b0, 1'b0);
        idle(2);
        do_cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        do_cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("t3_frozen", 32'(remaining), 32'd2);
        check("t3_not_done", 32'(done), 32'd0);
        idle(2);
        check("t3_done_6_edges", 32'(done), 32'd1);
        check("t3_steps", 32'(dut_steps - base), 32'd4);
        do_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // 4: load 6, abort at remaining 3
        base = dut_steps;
        do_cycle(1'b1, 6, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("t4_rem3", 32'(remaining), 32'd3);
        do_cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("t4_idle_rem", 32'(remaining), 32'd0);
        check("t4_idle_busy", 32'(busy), 32'd0);
        idle(3);
        check("t4_no_done", 32'(done), 32'd0);
        check("t4_steps", 32'(dut_steps - base), 32'd3);

        // 5: asynchronous reset mid-run at remaining 4
        do_cycle(1'b1, 7, 1'b0, 1'b0, 1'b0);
        idle(3);
        #2;
        reset = 1'b0;
        #1;
        check("t5_step", 32'(step), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_remaining", 32'(remaining), 32'd0);
        m_run = 1'b0;
        m_fin = 1'b0;
        m_rem = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(3);

        // 6: load 7 runs to completion; start in RUN and in DONE is ignored
        base = dut_steps;
        do_cycle(1'b1, 7, 1'b0, 1'b0, 1'b0);
        idle(1);
        do_cycle(1'b1, 3, 1'b0, 1'b0, 1'b0);
        idle(5);
        check("t6_steps", 32'(dut_steps - base), 32'd7);
        check("t6_done", 32'(done), 32'd1);
        do_cycle(1'b1, 5, 1'b0, 1'b0, 1'b1);
        check("t6_no_restart_busy", 32'(busy), 32'd0);
        check("t6_no_restart_done", 32'(done), 32'd0);
        idle(1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom % 4) == 0, int'($urandom_range(0, 7)),
                     ($urandom % 4) == 0, ($urandom % 16) == 0, ($urandom % 3) == 0);
        end
        check("rand_step_total", 32'(dut_steps), 32'(m_steps));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
